// File: rtl/addrreturn.sv
// Return path for one crossbar master: in-order FIFO of decoded targets that steers slave responses back.
// Optional head timeout is compiled in with ADDRRETURN_TIMEOUT_EN.
module addrreturn #(
  parameter int NS           = 8,
  parameter int DW           = 32,
  parameter int LGDEPTH      = 3,
`ifdef ADDRRETURN_TIMEOUT_EN
  parameter int LGTIMEOUT    = 10,
`endif
  parameter bit OPT_LOWPOWER = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_abort,
  input  logic               i_req_valid,
  output logic               o_req_stall,
  input  logic [NS:0]        i_req_decode,
  input  logic [NS-1:0]      i_slv_ack,
  input  logic [NS-1:0]      i_slv_err,
  input  logic [NS*DW-1:0]   i_slv_data,
  output logic               o_ack,
  output logic               o_err,
  output logic [DW-1:0]      o_data,
  output logic [LGDEPTH:0]   o_outstanding,
  output logic               o_protocol_err
);

  localparam int IW    = $clog2(NS + 1);
  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [IW-1:0]    NO_SLV = IW'(NS);
  localparam logic [LGDEPTH:0] FULL   = (LGDEPTH + 1)'(DEPTH);

  logic [IW-1:0]      fifo_q [DEPTH];
  logic [LGDEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LGDEPTH:0]   count_q, count_d;
  logic               ack_q, ack_d, err_q, err_d, perr_q, perr_d;
  logic [DW-1:0]      data_q, data_d;

  logic          accept, pop, head_valid, head_none;
  logic [IW-1:0] head_idx, push_idx;
  logic          hit_ack, hit_err, slv_pop, stray, tmo_pop;
  logic [DW-1:0] hit_data;

  assign o_req_stall    = (count_q == FULL) || i_abort;
  assign accept         = i_req_valid && !o_req_stall;
  assign head_valid     = (count_q != '0);
  assign head_idx       = fifo_q[rd_ptr_q];
  assign head_none      = head_valid && (head_idx == NO_SLV);
  assign o_ack          = ack_q;
  assign o_err          = err_q;
  assign o_data         = data_q;
  assign o_outstanding  = count_q;
  assign o_protocol_err = perr_q;

  // Anything other than exactly one slave bit is routed to the bus-error path.
  always_comb begin
    int ones;
    logic [IW-1:0] enc;
    ones = 0;
    enc  = NO_SLV;
    push_idx = NO_SLV;
    for (int k = 0; k <= NS; k++) begin
      if (i_req_decode[k]) begin
        ones = ones + 1;
        enc  = IW'(k);
      end
    end
    if (ones == 1) push_idx = enc;
  end

  // Only the head slave may answer; any other responder is recorded and ignored.
  always_comb begin
    hit_ack  = 1'b0;
    hit_err  = 1'b0;
    hit_data = '0;
    stray    = 1'b0;
    for (int k = 0; k < NS; k++) begin
      if (i_slv_ack[k] || i_slv_err[k]) begin
        if (head_valid && (head_idx == IW'(k))) begin
          hit_ack  = i_slv_ack[k];
          hit_err  = i_slv_err[k];
          hit_data = i_slv_data[k*DW +: DW];
        end else begin
          stray = 1'b1;
        end
      end
    end
    slv_pop = hit_ack || hit_err;
  end

`ifdef ADDRRETURN_TIMEOUT_EN
  localparam int TW = LGTIMEOUT + 1;
  logic [TW-1:0] timer_q, timer_d;

  assign tmo_pop = head_valid && !head_none && !slv_pop
                   && (timer_q == TW'(1 << LGTIMEOUT));

  always_comb begin
    timer_d = timer_q + TW'(1);
    if (i_abort || pop || !head_valid || (accept && count_q == '0))
      timer_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`else
  assign tmo_pop = 1'b0;
`endif

  assign pop = head_none || slv_pop || tmo_pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + LGDEPTH'(accept);
    rd_ptr_d = rd_ptr_q + LGDEPTH'(pop);
    count_d  = count_q + (LGDEPTH + 1)'(accept) - (LGDEPTH + 1)'(pop);
    ack_d    = slv_pop && hit_ack && !hit_err;
    err_d    = hit_err || head_none || tmo_pop;
    perr_d   = perr_q || stray;
    if (OPT_LOWPOWER)
      data_d = ack_d ? hit_data : '0;
    else if (slv_pop)
      data_d = hit_data;
    else if (err_d)
      data_d = '0;
    else
      data_d = data_q;
    if (i_abort) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      data_d   = OPT_LOWPOWER ? '0 : data_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      perr_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      data_q   <= data_d;
      perr_q   <= perr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) fifo_q[wr_ptr_q] <= push_idx;
  end

endmodule

// File: doc/addrreturn.md
Name: addrreturn

Overview:
- Return-path companion to the crossbar address decoder. It accepts each decoded request (one-hot, NS+1 bits, bit NS = "no slave matched").
- It records the target of every outstanding request in an in-order FIFO and steers the matching slave's ack/err/data back to the master, in issue order.
- For requests decoded to the no-slave bit it synthesises a bus error.
- It sits between the slave response wires and the master port of each crossbar master channel.

Parameters:
- NS, 8, number of slaves; decode width is NS+1.
- DW, 32, response data width.
- LGDEPTH, 3, log2 of the maximum number of outstanding requests (FIFO depth 2^LGDEPTH).
- OPT_LOWPOWER, 1, when set, o_data is forced to zero whenever o_ack is low.

Ports:
- i_clk  input  1  clock
- i_reset  input  1  synchronous active-high reset
- i_abort  input  1  flush all outstanding requests (master dropped its bus cycle)
- i_req_valid  input  1  decoded request presented
- o_req_stall  output  1  request not accepted this cycle
- i_req_decode  input  NS+1  one-hot target; bit NS = no slave
- i_slv_ack  input  NS  per-slave success response
- i_slv_err  input  NS  per-slave error response
- i_slv_data  input  NS*DW  per-slave read data, slave k at [k*DW +: DW]
- o_ack  output  1  response to master, success
- o_err  output  1  response to master, bus error
- o_data  output  DW  response data
- o_outstanding  output  LGDEPTH+1  count of accepted, unanswered requests
- o_protocol_err  output  1  sticky: a response arrived from a non-head slave

Behaviour:
- Clock and reset: clock i_clk; reset i_reset, synchronous, active-high.
- Reset values:
  - o_ack=0, o_err=0, o_data=0, o_outstanding=0, o_protocol_err=0.
  - FIFO empty; pointers zero.
- Accept:
  - A request is accepted when i_req_valid && !o_req_stall.
  - On accept, the encoded index of i_req_decode (0..NS) is pushed.
  - A non-one-hot or zero decode on accept is encoded as NS (error path).
- Stall: o_req_stall = (o_outstanding == 2^LGDEPTH) || i_abort.
  - Registered-count based; there is no same-cycle push-on-pop when full.
- Head:
  - The FIFO head is valid the cycle after its push, at the earliest.
  - Slaves never answer in their request cycle.
- Response, head index h < NS:
  - Wait for i_slv_ack[h] | i_slv_err[h].
  - Next cycle: o_ack = i_slv_ack[h] && !i_slv_err[h], o_err = i_slv_err[h], o_data = slave h's data slice.
  - Pop happens in the cycle the response is sampled.
  - Latency: 1 cycle from slave response to master.
- Response, head index h == NS:
  - Pop immediately when at head.
  - o_err = 1 the following cycle; o_data = 0.
- Output pulses:
  - o_ack and o_err are single-cycle pulses, mutually exclusive.
  - At most one pop per cycle, so at most one response per cycle.
- Counter:
  - o_outstanding += accept, -= pop.
  - Simultaneous accept and pop leaves it unchanged.
  - It never wraps: accept is blocked when full, pop is impossible when empty.
- Stray responses:
  - Any i_slv_ack/i_slv_err bit k where k is not the valid head index sets o_protocol_err sticky, until i_reset.
  - The stray response is discarded, and no pop occurs.
- Abort:
  - i_abort flushes the FIFO and clears o_outstanding next cycle.
  - It suppresses any o_ack/o_err that would have been produced next cycle.
  - o_protocol_err is retained.
- Reset mid-operation: all outstanding state is dropped; responses arriving the cycle after reset count as stray.
- Data path:
  - With OPT_LOWPOWER=1, o_data is 0 whenever o_ack = 0.
  - With OPT_LOWPOWER=0, o_data holds its last value.

Optional Feature:
- Macro: ADDRRETURN_TIMEOUT_EN.
- Defined:
  - Adds parameter LGTIMEOUT (default 10) and a counter that resets on every pop and on accept into an empty FIFO.
  - If the head is valid and unanswered for 2^LGTIMEOUT cycles, the head is popped and o_err pulses next cycle.
  - A late response from that slave then counts as stray.
- Undefined: no counter; the head waits indefinitely.

Test Plan:
- Single slave read: accept decode=0x004 (slave 2); 3 cycles later i_slv_ack[2]=1 with data 0xDEADBEEF -> next cycle o_ack=1, o_data=0xDEADBEEF, o_outstanding 1->0.
- No-slave error: accept decode=0x100 (NS=8) -> two cycles after accept o_err=1, o_ack=0, o_data=0.
- In-order and stray: issue to slave 1 then slave 3; slave 3 acks first -> o_protocol_err=1, no output; slave 1 acks -> o_ack with slave 1 data; slave 3 acks again -> o_ack with slave 3 data.
- Full: issue 8 requests with no acks -> o_outstanding=8, o_req_stall=1; a 9th valid request is not accepted; one ack -> stall drops the cycle after the pop.
- Abort/reset: 4 outstanding, assert i_abort with an ack pending the same cycle -> no o_ack next cycle, o_outstanding=0. Repeat with i_reset -> all outputs 0.
- Timeout (ADDRRETURN_TIMEOUT_EN, LGTIMEOUT=4): issue to slave 5, no ack -> o_err pulses at cycle 17 after head valid; a late ack from slave 5 sets o_protocol_err.
